if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the 8-bit pipelined processor. It owns the program counter and issues fetches to the synchronous instruction memory. It absorbs the one-cycle memory latency with a single-entry skid buffer. It presents a registered instruction, PC+1 and valid flag to the decode stage, which feeds the ID/EX pipeline register. It also honours load-use stalls from the hazard unit and branch, jump and jalr redirects from execute.

## Interface
- RESET_PC, 8'h00: PC value loaded on reset.
- INSTR_W, 16: instruction word width.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- stall  in  1  hold request from hazard unit; freezes PC and output register.
- redirect_valid  in  1  taken branch, jump or jalr from EX; has priority over stall.
- redirect_pc  in  8  target address, sampled when redirect_valid=1.
- imem_en  out  1  fetch request this cycle (combinational).
- imem_addr  out  8  fetch address; always equals the internal pc register.
- imem_rdata  in  INSTR_W  memory data, valid the cycle after imem_en=1.
- instr_out  out  INSTR_W  registered instruction to decode; 0 (NOP) when valid_out=0.
- pcp1_out  out  8  registered (fetch address + 1) mod 256 for that instruction.
- valid_out  out  1  instr_out/pcp1_out hold a real instruction.

## Operation
- State: pc[7:0]; req_valid and req_pcp1 track the in-flight fetch. skid_valid, skid_instr and skid_pcp1 form the skid buffer. The output register holds valid_out, instr_out and pcp1_out. A 2-bit FSM holds the current state.
- FSM states: BOOT, RUN, HOLD.
  - BOOT: entered on reset. No fetch issued. It moves to RUN unconditionally on the next edge.
  - RUN: imem_en=1 unless redirect_valid=1 or stall=1. Moves to HOLD when stall=1 and redirect_valid=0.
  - HOLD: imem_en=0. Moves to RUN when stall=0 or redirect_valid=1.
- Fetch issue (imem_en=1) updates: pc <= pc+1 (8-bit wrap, 8'hFF -> 8'h00), req_valid <= 1, req_pcp1 <= pc+1. With no issue, req_valid <= 0.
- Output register load, when stall=0 and redirect_valid=0:
  - skid_valid=1: output takes the skid contents, valid_out <= 1, and skid_valid <= 0.
  - else if req_valid=1: output takes imem_rdata and req_pcp1, with valid_out <= 1.
  - else: valid_out <= 0 and instr_out <= 0.
- Stall (stall=1, redirect_valid=0):
  - Output register and pc hold.
  - If req_valid=1, the returning imem_rdata and req_pcp1 are written into the skid buffer and skid_valid <= 1.
  - The skid buffer never needs a second entry, because no fetch issues while stalled.
- Skid drain: on the cycle stall falls with skid_valid=1, the output register takes the skid contents. A new fetch at pc issues in the same cycle. No instruction is lost or duplicated.
- Redirect (redirect_valid=1, any stall value):
  - pc <= redirect_pc.
  - imem_en=0 for the cycle.
  - req_valid <= 0; the data returning this cycle is discarded.
  - skid_valid <= 0.
  - valid_out <= 0 and instr_out <= 0.
  - FSM goes to RUN.
- Simultaneous stall and redirect: the redirect wins, and the stall is ignored for that cycle.

## Timing
- Reset values:
  - pc=RESET_PC.
  - req_valid, skid_valid and valid_out are 0.
  - instr_out=0, pcp1_out=0, skid_instr=0, skid_pcp1=0.
  - FSM=BOOT.
  - imem_en=0 during reset and in BOOT.
- Reset is asynchronous in both directions of effect: asserting rst_n=0 mid-stall or mid-redirect immediately clears all of the above. The first fetch after deassertion issues one cycle after the first edge, from BOOT.
- Fetch-to-output latency:
  - Address issued in cycle N; imem_rdata arrives in cycle N+1.
  - The instruction is visible on instr_out in N+2.
- Steady state: one instruction per cycle.
- Redirect penalty: redirect in cycle R, target fetched in R+1, target on instr_out in R+3. Outputs show 2 bubble cycles (R+1, R+2).
- Stall semantics: outputs stable on every cycle stall=1. The first new output appears the edge after stall falls.

## Test plan
- Reset/boot: imem returns 16'h1000+addr. Release rst_n. Required: imem_addr=00 with imem_en=0 for the first cycle, then fetches 00, 01, 02. instr_out=1000 with pcp1_out=01 appears 2 cycles after the first fetch, followed by 1001 and 1002 back-to-back.
- Stall with in-flight capture: assert stall for 3 cycles while 1003 is in flight. Required: instr_out held at 1002 throughout; the skid buffer captures 1003. After release, 1003 then 1004 appear with no gap or duplicate.
- Redirect: redirect_valid=1, redirect_pc=8'h40 while 1005 is in flight. Required: 1005 is discarded and valid_out=0 for 2 cycles. Then instr_out=1040 with pcp1_out=41.
- Redirect during stall with a full skid buffer: required: the skid contents are dropped and instr_out is never 1003-like stale data. The first valid instruction out is the target.
- Wrap: redirect to 8'hFE. Required: pcp1_out sequence FF, 00, 01; imem_addr wraps FF -> 00.
- Reset mid-stall: drop rst_n while skid_valid=1. Required: valid_out=0, skid cleared and pc=RESET_PC immediately. Restart matches the boot scenario.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches from a synchronous instruction
// memory, hides the one-cycle read latency with a single-entry skid buffer.
module if_stage #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter int         INSTR_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [7:0]         redirect_pc,
    output logic               imem_en,
    output logic [7:0]         imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic [7:0]         pcp1_out,
    output logic               valid_out
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [7:0]           pc_reg;
    logic [7:0]           pc_inc;
    logic                 req_valid_reg;
    logic [7:0]           req_pcp1_reg;
    logic                 skid_valid_reg;
    logic [INSTR_W-1:0]   skid_instr_reg;
    logic [7:0]           skid_pcp1_reg;
    logic                 advance;

    assign advance   = !stall && !redirect_valid;
    assign pc_inc    = pc_reg + 8'd1;
    assign imem_addr = pc_reg;

    // Leaving HOLD fetches in the same cycle the skid drains, so the stream has no gap.
    always_comb begin
        state_next = state_reg;
        imem_en    = 1'b0;
        case (state_reg)
            BOOT: state_next = RUN;
            RUN: begin
                imem_en = advance;
                if (stall && !redirect_valid)
                    state_next = HOLD;
            end
            HOLD: begin
                imem_en = advance;
                if (!stall || redirect_valid)
                    state_next = RUN;
            end
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= BOOT;
            pc_reg        <= RESET_PC;
            req_valid_reg <= 1'b0;
            req_pcp1_reg  <= 8'h00;
        end else begin
            state_reg     <= state_next;
            req_valid_reg <= imem_en;
            if (redirect_valid) begin
                pc_reg <= redirect_pc;
            end else if (imem_en) begin
                pc_reg       <= pc_inc;
                req_pcp1_reg <= pc_inc;
            end
        end
    end

    // Skid buffer: catches the fetch that lands while the output register is frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_reg <= 1'b0;
            skid_instr_reg <= '0;
            skid_pcp1_reg  <= 8'h00;
        end else if (redirect_valid) begin
            skid_valid_reg <= 1'b0;
        end else if (stall) begin
            if (req_valid_reg) begin
                skid_valid_reg <= 1'b1;
                skid_instr_reg <= imem_rdata;
                skid_pcp1_reg  <= req_pcp1_reg;
            end
        end else begin
            skid_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            instr_out <= '0;
            pcp1_out  <= 8'h00;
        end else if (redirect_valid) begin
            valid_out <= 1'b0;
            instr_out <= '0;
        end else if (!stall) begin
            if (skid_valid_reg) begin
                valid_out <= 1'b1;
                instr_out <= skid_instr_reg;
                pcp1_out  <= skid_pcp1_reg;
            end else if (req_valid_reg) begin
                valid_out <= 1'b1;
                instr_out <= imem_rdata;
                pcp1_out  <= req_pcp1_reg;
            end else begin
                valid_out <= 1'b0;
                instr_out <= '0;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Randomized scoreboard bench for if_stage: a fetch-credit model predicts the
// delivered instruction stream; a monitor pops and compares at each output update.
module tb_if_stage;

    localparam logic [7:0] RESET_PC = 8'h00;

    typedef struct packed {
        logic [15:0] instr;
        logic [7:0]  pcp1;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic [15:0] instr_out;
    logic [7:0]  pcp1_out;
    logic        valid_out;

    logic [15:0] mem [256];
    entry_t      sb [$];
    logic [7:0]  model_pc;
    logic        boot;
    logic        mon_en;
    int          n_checks;
    int          n_pass;

    if_stage #(.RESET_PC(RESET_PC), .INSTR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .instr_out(instr_out), .pcp1_out(pcp1_out),
        .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_en)
            imem_rdata <= mem[imem_addr];
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
    endtask

    // Called just after a negedge; returns at the following negedge.
    task automatic step(input logic s, input logic r, input logic [7:0] t);
        logic exp_en;
        stall          = s;
        redirect_valid = r;
        redirect_pc    = t;
        exp_en         = !boot && !s && !r;
        if (r)
            sb.delete();
        #1;
        chk("imem_en", {31'd0, imem_en}, {31'd0, exp_en});
        chk("imem_addr", {24'd0, imem_addr}, {24'd0, model_pc});
        $display("cyc stall=%0b redir=%0b tgt=%h en=%0b addr=%h out_v=%0b instr=%h pcp1=%h",
                 s, r, t, imem_en, imem_addr, valid_out, instr_out, pcp1_out);
        @(posedge clk);
        #2;
        if (exp_en)
            sb.push_back('{instr: mem[model_pc], pcp1: model_pc + 8'd1});
        if (r)
            model_pc = t;
        else if (exp_en)
            model_pc = model_pc + 8'd1;
        boot = 1'b0;
        @(negedge clk);
    endtask

    task automatic release_reset();
        rst_n          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        model_pc       = RESET_PC;
        sb.delete();
        boot           = 1'b1;
        mon_en         = 1'b1;
    endtask

    // Asynchronous reset asserted mid-cycle; effects must be visible immediately.
    task automatic mid_reset();
        mon_en = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
        chk("rst_instr_out", {16'd0, instr_out}, 32'd0);
        chk("rst_pcp1_out", {24'd0, pcp1_out}, 32'd0);
        chk("rst_imem_en", {31'd0, imem_en}, 32'd0);
        chk("rst_imem_addr", {24'd0, imem_addr}, {24'd0, RESET_PC});
        stall          = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        release_reset();
    endtask

    // Monitor: outputs change only on edges with neither stall nor redirect.
    initial begin
        logic        pv;
        logic [15:0] pi;
        logic [7:0]  pp;
        entry_t      e;
        pv = 1'b0; pi = '0; pp = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && rst_n) begin
                if (redirect_valid) begin
                    chk("redir_valid", {31'd0, valid_out}, 32'd0);
                    chk("redir_instr", {16'd0, instr_out}, 32'd0);
                end else if (stall) begin
                    chk("stall_hold_valid", {31'd0, valid_out}, {31'd0, pv});
                    chk("stall_hold_instr", {16'd0, instr_out}, {16'd0, pi});
                    if (pv)
                        chk("stall_hold_pcp1", {24'd0, pcp1_out}, {24'd0, pp});
                end else if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("out_valid", {31'd0, valid_out}, 32'd1);
                    chk("out_instr", {16'd0, instr_out}, {16'd0, e.instr});
                    chk("out_pcp1", {24'd0, pcp1_out}, {24'd0, e.pcp1});
                end else begin
                    chk("bubble_valid", {31'd0, valid_out}, 32'd0);
                    chk("bubble_instr", {16'd0, instr_out}, 32'd0);
                end
            end
            pv = valid_out;
            pi = instr_out;
            pp = pcp1_out;
        end
    end

    initial begin
        n_checks       = 0;
        n_pass         = 0;
        mon_en         = 1'b0;
        boot           = 1'b1;
        model_pc       = RESET_PC;
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        imem_rdata     = '0;
        for (int i = 0; i < 256; i++)
            mem[i] = 16'($urandom);
        #1;
        chk("init_valid_out", {31'd0, valid_out}, 32'd0);
        chk("init_imem_en", {31'd0, imem_en}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        release_reset();

        // Boot and steady stream
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00);
        // Stall with a fetch in flight, then release
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00);
        // Redirect with a fetch in flight
        step(1'b0, 1'b1, 8'h40);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00);
        // Redirect while stalled with a full skid buffer
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h10);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00);
        // Wrap past 8'hFF
        step(1'b0, 1'b1, 8'hFE);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00);
        // Single-cycle stall
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
        // Reset while the skid buffer holds data
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 8'h00);
        mid_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                mid_reset();
            end else begin
                step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                     8'($urandom_range(0, 255)));
            end
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
